ticket_vendor_fsm: RTL and testbench
====================================

// Module: ticket_vendor_fsm
// PURPOSE
//  Clocked, parametrised ticket-vending controller; sequential successor to the combinational seller.
//  Accepts a ticket-count request, then collects coins (1/5/10) one per cycle.
//  Dispenses tickets one pulse per cycle, then returns change greedily, one coin per cycle.
//  Sits between the coin acceptor / keypad front end and the ticket and coin hopper drivers.
// PARAMETERS
//  TICKET_PRICE  3   price of one ticket, in 1-unit coins
//  MAX_TICKETS   10  largest legal request
//  TKT_W         4   width of the request field
//  AMT_W         8   width of the paid/due/change registers.
//                    Elaboration error unless MAX_TICKETS*TICKET_PRICE+9 < 2**AMT_W.
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  req_valid    in   1      request strobe
//  req_tickets  in   TKT_W  number of tickets requested
//  req_ready    out  1      high only in IDLE
//  coin_valid   in   1      coin-inserted strobe, one per cycle max
//  coin_type    in   2      00 none, 01 = 1, 10 = 5, 11 = 10
//  cancel       in   1      refund request; present only with SELLER_CANCEL_EN
//  tkt_out      out  1      one-cycle pulse per ticket dispensed
//  chg_out      out  1      one-cycle pulse per change coin
//  chg_type     out  2      denomination of the chg_out coin (same encoding as coin_type); 00 when idle
//  coin_rej     out  1      pulse: coin_valid arrived outside COLLECT; that coin is not counted
//  err          out  1      pulse: illegal request
//  done         out  1      pulse on the final cycle of a transaction
//  paid         out  AMT_W  running coin total
//  busy         out  1      high when not in IDLE
// BEHAVIOUR
//  Outputs and reset:
//  - All outputs are registered.
//  - rst=1 forces IDLE and clears paid/due/change/ticket counter.
//  - Every output resets to 0, except req_ready, which resets to 1.
//  - rst takes priority over everything, including mid-VEND and mid-CHANGE; no partial output completes.
//  States: IDLE -> COLLECT -> VEND -> CHANGE -> IDLE.
//  IDLE:
//  - Request accepted when req_valid & req_ready.
//  - req_tickets==0 or >MAX_TICKETS: err=1 next cycle, stay IDLE.
//  - Otherwise latch n=req_tickets, due=n*TICKET_PRICE, paid=0, go COLLECT.
//  - coin_valid in IDLE -> coin_rej.
//  COLLECT:
//  - Each coin_valid with nonzero type adds 1/5/10 to paid.
//  - coin_valid with type 00 is ignored, no coin_rej.
//  - When the updated paid >= due, the next state is VEND. Overflow is impossible by the parameter check.
//  VEND:
//  - tkt_out=1 for exactly n consecutive cycles.
//  - change=paid-due is latched on entry.
//  - Then go to CHANGE, or to IDLE with done when change==0.
//  CHANGE:
//  - Each cycle emits the largest denomination <= remaining (10, then 5, then 1).
//  - chg_out=1 with chg_type; remaining is decremented by that value.
//  - The coin that empties remaining is emitted together with done=1; next state IDLE; paid clears on IDLE entry.
//  Other rules:
//  - coin_valid in VEND or CHANGE -> coin_rej pulse; paid is unchanged.
//  - req_valid outside IDLE is ignored; req_ready=0 there.
//  - Latencies: first tkt_out is 1 cycle after the coin that satisfies due.
//    A request with exact payment and n tickets completes done n cycles after that coin.
// CONFIGURATION
//  Macro SELLER_CANCEL_EN, defined:
//  - cancel port exists; cancel=1 in COLLECT jumps to CHANGE with remaining=paid.
//  - No tickets are dispensed.
//  - A coin in the same cycle as cancel is counted first, then refunded.
//  - paid==0 goes straight to IDLE with done.
//  - cancel is ignored in all other states.
//  Macro SELLER_CANCEL_EN, undefined: no cancel port; COLLECT exits only by payment or rst.
// STRUCTURE
//  Shared include seller_defs.vh:
//  - state encodings;
//  - coin codes COIN_NONE/COIN_1/COIN_5/COIN_10;
//  - coin values VAL_1=1, VAL_5=5, VAL_10=10.
//  Sub-module change_dispenser: combinational greedy select.
//  - Input: remaining. Outputs: chg_type and the decrement value.
//  - Instantiated once inside the FSM.
// TESTING
//  1. req 2; coins 5,1 -> paid=6, 2 tkt_out pulses, no chg_out, done.
//  2. req 1; coin 10 -> 1 tkt_out; chg_type 10(5),01,01 over 3 cycles (change 7), done on 3rd.
//  3. req 0, then req 11 -> err pulse each, state IDLE, req_ready=1, no tkt_out.
//  4. (SELLER_CANCEL_EN) req 4; coins 5,5; cancel -> one chg_out type 11 (10), zero tkt_out, done.
//  5. req 3; coins 10 then coin 1 during VEND -> coin_rej=1, paid stays 10, change 1.
//  6. rst asserted in 2nd VEND cycle of req 3 -> next cycle all outputs 0, req_ready=1, no further tkt_out.

Source files
------------

// File: rtl/ticket_vendor_fsm_pkg.sv
// Shared definitions for the ticket vendor: FSM states, coin codes and coin values.
package ticket_vendor_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_5    = 2'b10,
    COIN_10   = 2'b11
  } coin_t;

  localparam int unsigned VAL_1  = 1;
  localparam int unsigned VAL_5  = 5;
  localparam int unsigned VAL_10 = 10;

  function automatic logic [3:0] coin_value(input coin_t c);
    case (c)
      COIN_1:  return 4'(VAL_1);
      COIN_5:  return 4'(VAL_5);
      COIN_10: return 4'(VAL_10);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/ticket_vendor_fsm_change_dispenser.sv
// Greedy change selector: picks the largest coin not exceeding the remaining amount.
module change_dispenser
  import ticket_vendor_fsm_pkg::*;
#(
  parameter int unsigned AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  output logic [1:0]       chg_type,
  output logic [AMT_W-1:0] dec
);

  always_comb begin
    chg_type = COIN_NONE;
    dec      = '0;
    if (remaining >= AMT_W'(VAL_10)) begin
      chg_type = COIN_10;
      dec      = AMT_W'(VAL_10);
    end else if (remaining >= AMT_W'(VAL_5)) begin
      chg_type = COIN_5;
      dec      = AMT_W'(VAL_5);
    end else if (remaining != '0) begin
      chg_type = COIN_1;
      dec      = AMT_W'(VAL_1);
    end
  end

endmodule

// File: rtl/ticket_vendor_fsm.sv
// Clocked ticket-vending controller: request, coin collection, ticket dispense, greedy change.
// Optional refund path enabled by defining SELLER_CANCEL_EN (adds the cancel port).
module ticket_vendor_fsm
  import ticket_vendor_fsm_pkg::*;
#(
  parameter int unsigned TICKET_PRICE = 3,
  parameter int unsigned MAX_TICKETS  = 10,
  parameter int unsigned TKT_W        = 4,
  parameter int unsigned AMT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [TKT_W-1:0] req_tickets,
  output logic             req_ready,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
`ifdef SELLER_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             tkt_out,
  output logic             chg_out,
  output logic [1:0]       chg_type,
  output logic             coin_rej,
  output logic             err,
  output logic             done,
  output logic [AMT_W-1:0] paid,
  output logic             busy
);

  if (MAX_TICKETS * TICKET_PRICE + 9 >= 2 ** AMT_W) begin : g_bad_params
    $error("ticket_vendor_fsm: AMT_W too narrow for MAX_TICKETS*TICKET_PRICE+9");
  end

  localparam logic [TKT_W-1:0] MAX_T = TKT_W'(MAX_TICKETS);
  localparam logic [TKT_W-1:0] ONE_T = TKT_W'(1);

  state_t           state_q, state_n;
  logic [TKT_W-1:0] n_q, n_n, tkt_left_q, tkt_left_n;
  logic [AMT_W-1:0] due_q, due_n, change_q, change_n, paid_n;
  logic [AMT_W-1:0] coin_val, paid_add, chg_src, disp_dec;
  logic [1:0]       disp_type, chg_type_n;
  logic             tkt_out_n, chg_out_n, coin_rej_n, err_n, done_n;
  logic             do_chg, go_idle, legal;

  assign coin_val = coin_valid ? AMT_W'(coin_value(coin_t'(coin_type))) : '0;
  assign paid_add = paid + coin_val;
  assign legal    = (req_tickets != '0) && (req_tickets <= MAX_T);
  // A cancel refunds the running total including this cycle's coin; otherwise draw on stored change.
  assign chg_src  = (state_q == S_COLLECT) ? paid_add : change_q;

  change_dispenser #(.AMT_W(AMT_W)) u_disp (
    .remaining (chg_src),
    .chg_type  (disp_type),
    .dec       (disp_dec)
  );

  // Outputs are computed one cycle ahead so that each registered pulse lands in the
  // cycle it belongs to, with done coinciding with the last ticket or change coin.
  always_comb begin
    state_n    = state_q;
    n_n        = n_q;
    tkt_left_n = tkt_left_q;
    due_n      = due_q;
    paid_n     = paid;
    change_n   = change_q;
    tkt_out_n  = 1'b0;
    chg_out_n  = 1'b0;
    chg_type_n = COIN_NONE;
    coin_rej_n = 1'b0;
    err_n      = 1'b0;
    done_n     = 1'b0;
    do_chg     = 1'b0;
    go_idle    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        coin_rej_n = coin_valid;
        if (req_valid && req_ready) begin
          if (!legal) begin
            err_n = 1'b1;
          end else begin
            n_n     = req_tickets;
            due_n   = AMT_W'(req_tickets) * AMT_W'(TICKET_PRICE);
            paid_n  = '0;
            state_n = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        paid_n = paid_add;
`ifdef SELLER_CANCEL_EN
        if (cancel) begin
          if (paid_add == '0) begin
            go_idle = 1'b1;
            done_n  = 1'b1;
          end else begin
            do_chg = 1'b1;
          end
        end else
`endif
        if (paid_add >= due_q) begin
          state_n    = S_VEND;
          tkt_out_n  = 1'b1;
          tkt_left_n = n_q - ONE_T;
          change_n   = paid_add - due_q;
          done_n     = (n_q == ONE_T) && (paid_add == due_q);
        end
      end
      S_VEND: begin
        coin_rej_n = coin_valid;
        if (tkt_left_q != '0) begin
          tkt_out_n  = 1'b1;
          tkt_left_n = tkt_left_q - ONE_T;
          done_n     = (tkt_left_q == ONE_T) && (change_q == '0);
        end else if (change_q == '0) begin
          go_idle = 1'b1;
        end else begin
          do_chg = 1'b1;
        end
      end
      S_CHANGE: begin
        coin_rej_n = coin_valid;
        if (change_q == '0) go_idle = 1'b1;
        else                do_chg  = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase
    if (do_chg) begin
      state_n    = S_CHANGE;
      chg_out_n  = 1'b1;
      chg_type_n = disp_type;
      change_n   = chg_src - disp_dec;
      done_n     = (chg_src == disp_dec);
    end
    if (go_idle) begin
      state_n  = S_IDLE;
      paid_n   = '0;
      change_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      tkt_left_q <= '0;
      due_q      <= '0;
      change_q   <= '0;
      paid       <= '0;
      tkt_out    <= 1'b0;
      chg_out    <= 1'b0;
      chg_type   <= '0;
      coin_rej   <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state_q    <= state_n;
      n_q        <= n_n;
      tkt_left_q <= tkt_left_n;
      due_q      <= due_n;
      change_q   <= change_n;
      paid       <= paid_n;
      tkt_out    <= tkt_out_n;
      chg_out    <= chg_out_n;
      chg_type   <= chg_type_n;
      coin_rej   <= coin_rej_n;
      err        <= err_n;
      done       <= done_n;
      busy       <= (state_n != S_IDLE);
      req_ready  <= (state_n == S_IDLE);
    end
  end

endmodule

// File: tb/tb_ticket_vendor_fsm.sv
// Self-checking bench for ticket_vendor_fsm: transaction-level reference model plus directed scenarios.
module tb_ticket_vendor_fsm;

  localparam int PRICE = 3;
  localparam int MAXT  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_tickets = '0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = '0;
  logic       cancel = 1'b0;
  logic       req_ready, tkt_out, chg_out, coin_rej, err, done, busy;
  logic [1:0] chg_type;
  logic [7:0] paid;

  ticket_vendor_fsm #(
    .TICKET_PRICE(PRICE),
    .MAX_TICKETS (MAXT),
    .TKT_W       (4),
    .AMT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_tickets(req_tickets),
    .req_ready  (req_ready),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
`ifdef SELLER_CANCEL_EN
    .cancel     (cancel),
`endif
    .tkt_out    (tkt_out),
    .chg_out    (chg_out),
    .chg_type   (chg_type),
    .coin_rej   (coin_rej),
    .err        (err),
    .done       (done),
    .paid       (paid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a transaction is a queue of output cycles (tickets, then change coins).
  typedef struct packed {
    logic       tkt;
    logic       chg;
    logic [1:0] typ;
    logic       dn;
  } ev_t;

  ev_t q[$];
  int  m_mode = 0;  // 0 idle, 1 collecting, 2 emitting queued outputs
  int  m_paid = 0, m_due = 0, m_n = 0;
  logic e_tkt, e_chg, e_rej, e_err, e_done, e_busy, e_ready;
  logic [1:0] e_typ;
  int  e_paid;

  function automatic int coin_val(input logic [1:0] c);
    case (c)
      2'd1:    return 1;
      2'd2:    return 5;
      2'd3:    return 10;
      default: return 0;
    endcase
  endfunction

  task automatic build(input int tk, input int ch);
    ev_t e;
    for (int i = 0; i < tk; i++) begin e = '0; e.tkt = 1'b1; q.push_back(e); end
    for (int i = 0; i < ch / 10; i++) begin e = '0; e.chg = 1'b1; e.typ = 2'b11; q.push_back(e); end
    for (int i = 0; i < (ch % 10) / 5; i++) begin e = '0; e.chg = 1'b1; e.typ = 2'b10; q.push_back(e); end
    for (int i = 0; i < ch % 5; i++) begin e = '0; e.chg = 1'b1; e.typ = 2'b01; q.push_back(e); end
    e = q.pop_back();
    e.dn = 1'b1;
    q.push_back(e);
  endtask

  task automatic pop_ev();
    ev_t e;
    e = q.pop_front();
    e_tkt = e.tkt; e_chg = e.chg; e_typ = e.typ; e_done = e.dn;
  endtask

  always @(posedge clk) begin
    e_tkt = 0; e_chg = 0; e_typ = 0; e_rej = 0; e_err = 0; e_done = 0;
    if (rst) begin
      m_mode = 0; m_paid = 0; q.delete();
    end else begin
      if (coin_valid && m_mode != 1) e_rej = 1;
      case (m_mode)
        0: if (req_valid) begin
             if (req_tickets == 0 || int'(req_tickets) > MAXT) e_err = 1;
             else begin m_n = int'(req_tickets); m_due = m_n * PRICE; m_paid = 0; m_mode = 1; end
           end
        1: begin
             if (coin_valid) m_paid += coin_val(coin_type);
             if (cancel) begin
               if (m_paid == 0) begin e_done = 1; m_mode = 0; end
               else begin build(0, m_paid); pop_ev(); m_mode = 2; end
             end else if (m_paid >= m_due) begin
               build(m_n, m_paid - m_due); pop_ev(); m_mode = 2;
             end
           end
        default: if (q.size() == 0) begin m_mode = 0; m_paid = 0; end
                 else pop_ev();
      endcase
    end
    e_busy = (m_mode != 0); e_ready = (m_mode == 0); e_paid = m_paid;
  end

  int n_pass = 0, n_total = 0;
  int tkt_cnt, chg_cnt, done_cnt, err_cnt, rej_cnt, chg_word, chg_at_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_obs();
    tkt_cnt = 0; chg_cnt = 0; done_cnt = 0; err_cnt = 0; rej_cnt = 0; chg_word = 0; chg_at_done = -1;
  endtask

  task automatic step();
    logic [31:0] a, e;
    @(posedge clk);
    @(negedge clk);
    a = {15'b0, tkt_out, chg_out, chg_type, coin_rej, err, done, busy, req_ready, paid};
    e = {15'b0, e_tkt, e_chg, e_typ, e_rej, e_err, e_done, e_busy, e_ready, 8'(e_paid)};
    chk("cycle{tkt,chg,type,rej,err,done,busy,ready,paid}", a, e);
    tkt_cnt += int'(tkt_out); err_cnt += int'(err); rej_cnt += int'(coin_rej);
    if (chg_out) begin chg_cnt++; chg_word = chg_word * 4 + int'(chg_type); end
    if (done) begin done_cnt++; chg_at_done = chg_cnt; end
  endtask

  task automatic drive(input logic rv, input int rt, input logic cv, input logic [1:0] ct, input logic cn);
    req_valid = rv; req_tickets = 4'(rt); coin_valid = cv; coin_type = ct; cancel = cn;
  endtask

  task automatic idle(input int k);
    drive(0, 0, 0, 2'd0, 0);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    drive(0, 0, 0, 2'd0, 0);
    while (done_cnt == 0 && k < budget) begin step(); k++; end
    chk(name, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    clear_obs();
    step(); step();
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_busy_paid", {23'b0, busy, paid}, 32'd0);
    chk("reset_pulses", {26'b0, tkt_out, chg_out, chg_type, err, done}, 32'd0);
    rst = 1'b0;
    idle(1);

    // 1: req 2, coins 5 then 1, exact payment
    clear_obs();
    drive(1, 2, 0, 2'd0, 0); step();
    drive(0, 0, 1, 2'd2, 0); step();
    drive(0, 0, 1, 2'd1, 0); step();
    chk("t1_first_tkt_latency", 32'(tkt_out), 32'd1);
    chk("t1_paid", 32'(paid), 32'd6);
    wait_done("t1_done", 10);
    chk("t1_tkt_cnt", 32'(tkt_cnt), 32'd2);
    chk("t1_chg_cnt", 32'(chg_cnt), 32'd0);
    idle(2);
    chk("t1_idle_paid_ready", {23'b0, req_ready, paid}, 32'h100);

    // 2: req 1, coin 10 -> change 7 as 5,1,1
    clear_obs();
    drive(1, 1, 0, 2'd0, 0); step();
    drive(0, 0, 1, 2'd3, 0); step();
    chk("t2_tkt", 32'(tkt_out), 32'd1);
    wait_done("t2_done", 10);
    chk("t2_tkt_cnt", 32'(tkt_cnt), 32'd1);
    chk("t2_chg_seq", 32'(chg_word), 32'h25);
    chk("t2_done_on_3rd", 32'(chg_at_done), 32'd3);
    idle(2);

    // 3: illegal requests 0 and 11
    clear_obs();
    drive(1, 0, 0, 2'd0, 0); step();
    chk("t3_err0", 32'(err), 32'd1);
    idle(1);
    drive(1, 11, 0, 2'd0, 0); step();
    chk("t3_err11", 32'(err), 32'd1);
    idle(2);
    chk("t3_err_cnt", 32'(err_cnt), 32'd2);
    chk("t3_idle", {29'b0, req_ready, busy, tkt_out}, 32'd4);
    chk("t3_tkt_cnt", 32'(tkt_cnt), 32'd0);

`ifdef SELLER_CANCEL_EN
    // 4: req 4, coins 5,5, cancel -> refund one 10
    clear_obs();
    drive(1, 4, 0, 2'd0, 0); step();
    drive(0, 0, 1, 2'd2, 0); step();
    drive(0, 0, 1, 2'd2, 0); step();
    drive(0, 0, 0, 2'd0, 1); step();
    wait_done("t4_done", 10);
    chk("t4_chg", {30'b0, 2'(chg_word)}, 32'd3);
    chk("t4_chg_cnt", 32'(chg_cnt), 32'd1);
    chk("t4_tkt_cnt", 32'(tkt_cnt), 32'd0);
    idle(2);
    // coin and cancel together: coin counted then refunded
    clear_obs();
    drive(1, 1, 0, 2'd0, 0); step();
    drive(0, 0, 1, 2'd1, 1); step();
    chk("t4b_refund1", {30'b0, chg_out, done}, 32'd3);
    idle(2);
    // cancel with nothing paid
    clear_obs();
    drive(1, 2, 0, 2'd0, 0); step();
    drive(0, 0, 0, 2'd0, 1); step();
    chk("t4c_done_idle", {29'b0, done, req_ready, chg_out}, 32'd6);
    idle(2);
`endif

    // 5: coin inserted during VEND is rejected and not counted
    clear_obs();
    drive(1, 3, 0, 2'd0, 0); step();
    drive(0, 0, 1, 2'd3, 0); step();
    drive(0, 0, 1, 2'd1, 0); step();
    chk("t5_rej", 32'(coin_rej), 32'd1);
    chk("t5_paid", 32'(paid), 32'd10);
    wait_done("t5_done", 10);
    chk("t5_tkt_cnt", 32'(tkt_cnt), 32'd3);
    chk("t5_chg", {24'b0, 4'(chg_cnt), 4'(chg_word)}, 32'h11);
    idle(2);

    // 6: reset during the second VEND cycle
    clear_obs();
    drive(1, 3, 0, 2'd0, 0); step();
    drive(0, 0, 1, 2'd3, 0); step();
    idle(1);
    chk("t6_second_tkt", 32'(tkt_cnt), 32'd2);
    rst = 1'b1; step();
    chk("t6_reset_outputs", {15'b0, tkt_out, chg_out, chg_type, coin_rej, err, done, busy, req_ready, paid}, 32'h100);
    rst = 1'b0;
    idle(5);
    chk("t6_no_more_tkt", 32'(tkt_cnt), 32'd2);
    chk("t6_no_chg_done", 32'(chg_cnt + done_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
